// File: rtl/gpio_in.sv
// Buffered GPIO input block: synchronizes external 8-bit ports and latches
// per-bit change flags. Exposes value, flag and mask registers over an 8-bit bus.
module gpio_in #(
  parameter int size_addr = 2,
  parameter int size      = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 read,
  input  logic                 write,
  output logic                 ready_r,
  output logic                 ready_w,
  input  logic [size_addr-1:0] address,
  input  logic [7:0]           data_in,
  output logic [7:0]           data_out,
  input  logic [8*size-1:0]    pins_in,
  output logic                 irq
);

  localparam int W = 8 * size;

  logic [W-1:0] s1_q, s2_q, s3_q;
  logic [W-1:0] flags_q, flags_d;
  logic [W-1:0] mask_q, mask_d;
  logic [W-1:0] edge_s;
  logic [1:0]   warm_q, warm_d;
  logic         armed_s;
  logic [7:0]   rdata_s, data_out_q, data_out_d;
  logic         ready_r_q, ready_w_q;
  logic [31:0]  addr_s;

  assign addr_s  = 32'(address);
  assign edge_s  = s2_q ^ s3_q;
  assign armed_s = (warm_q == 2'd3);

  // Warm-up counter keeps flags quiet until the synchronizer has filled.
  always_comb begin
    if (warm_q == 2'd3) begin
      warm_d = 2'd3;
    end else begin
      warm_d = warm_q + 2'd1;
    end
  end

  // Read mux, flag set/clear and mask update; set takes priority over clear.
  always_comb begin
    rdata_s = 8'h00;
    flags_d = flags_q;
    mask_d  = mask_q;
    for (int p = 0; p < size; p++) begin
      if (addr_s == 32'(p)) begin
        rdata_s = s2_q[8*p +: 8];
      end else if (addr_s == 32'(size + p)) begin
        rdata_s = flags_q[8*p +: 8];
      end else if (addr_s == 32'(2*size + p)) begin
        rdata_s = mask_q[8*p +: 8];
      end else begin
        rdata_s = rdata_s;
      end

      if (write && (addr_s == 32'(size + p))) begin
        flags_d[8*p +: 8] = (flags_q[8*p +: 8] & ~data_in) | (edge_s[8*p +: 8] & {8{armed_s}});
      end else begin
        flags_d[8*p +: 8] = flags_q[8*p +: 8] | (edge_s[8*p +: 8] & {8{armed_s}});
      end

      if (write && (addr_s == 32'(2*size + p))) begin
        mask_d[8*p +: 8] = data_in;
      end else begin
        mask_d[8*p +: 8] = mask_q[8*p +: 8];
      end
    end
  end

  // Read data holds between reads.
  always_comb begin
    if (read) begin
      data_out_d = rdata_s;
    end else begin
      data_out_d = data_out_q;
    end
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      flags_q    <= '0;
      mask_q     <= '0;
      warm_q     <= 2'd0;
      data_out_q <= 8'h00;
      ready_r_q  <= 1'b0;
      ready_w_q  <= 1'b0;
    end else begin
      s1_q       <= pins_in;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      flags_q    <= flags_d;
      mask_q     <= mask_d;
      warm_q     <= warm_d;
      data_out_q <= data_out_d;
      ready_r_q  <= read;
      ready_w_q  <= write;
    end
  end

  assign data_out = data_out_q;
  assign ready_r  = ready_r_q;
  assign ready_w  = ready_w_q;
  assign irq      = |(flags_q & mask_q);

endmodule

// File: doc/gpio_in.md
# gpio_in

Buffered GPIO input block: the read-side counterpart of the buffered GPIO output block, on the same 8-bit memory-mapped bus. It synchronizes `size` external 8-bit input ports into the clock domain and latches per-bit change flags. It also holds per-bit interrupt masks and raises a level interrupt to the core. The CPU reads values and flags and writes masks and flag clears through the same read/write/ready handshake used by the output block.

## Interface
Parameters:
- `size_addr`, default 2: width of `address`; must satisfy 2^size_addr >= 3*size.
- `size`, default 1: number of 8-bit input ports.

Ports:
- `clk`  in  1  single system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `read`  in  1  read strobe, sampled each cycle.
- `write`  in  1  write strobe, sampled each cycle.
- `ready_r`  out  1  read acknowledge.
- `ready_w`  out  1  write acknowledge.
- `address`  in  size_addr  register select.
- `data_in`  in  8  write data.
- `data_out`  out  8  registered read data.
- `pins_in`  in  8*size  asynchronous external inputs; port p = bits [8p+7:8p].
- `irq`  out  1  interrupt, high while any unmasked change flag is set.

## Operation
- Register map, per port p in 0..size-1:
  - `value[p]` at address p: read-only; returns synchronized pin state.
  - `flags[p]` at address size+p: sticky change flags; write-1-to-clear.
  - `mask[p]` at address 2*size+p: interrupt enable bits; read/write.
- Addresses >= 3*size: reads return 0x00; writes are ignored. Both still acknowledge.
- Synchronizer: three flop stages per pin, s1 <= pins_in, s2 <= s1, s3 <= s2. `value` reads return s2.
- Edge detect: edge = s2 ^ s3, both rising and falling.
- Flag update each cycle: flags <= (flags & ~clr) | (edge & armed). clr = data_in when write hits that flags address, else 0.
- Simultaneous edge and clear on the same bit: set wins, and the flag stays 1.
- Arming: a 2-bit warm-up counter starts at 0 on reset and increments each cycle until it saturates at 3. armed = (counter == 3). This suppresses spurious flags while the synchronizer fills after reset.
- Mask write: mask[p] <= data_in.
- irq = OR over all p of (flags[p] & mask[p]). It is combinational from registers only.
- Read: on a cycle with read=1, data_out <= the addressed register's current (pre-update) contents. data_out holds until the next read.
- Read and write in the same cycle: both are serviced. The read returns the pre-write value.

## Timing
- Reset values (asynchronous, while reset=0): data_out=0x00, ready_r=0, ready_w=0, irq=0. All s1/s2/s3, flags, and mask registers are 0, and the warm-up counter is 0.
- Reset asserted mid-transaction clears everything immediately. A pending acknowledge is dropped.
- Handshake:
  - ready_r <= read and ready_w <= write, one cycle of latency. A strobe held N cycles gives N acknowledge cycles.
  - data_out is valid in the cycle ready_r=1.
  - Write effects (mask, flag clear) are visible to a read issued in the cycle after the write.
- Pin latency: a pin change captured into s1 at edge k appears in s2 at k+1. A read strobed in the cycle after k+1 returns the new value.
- The flag sets at edge k+2, and irq rises after edge k+2 if the bit is masked in.
- Pulses shorter than one clock may be missed. Pulses of two or more cycles always set their flag.
- After reset release, no flag may set before the 4th rising edge.

## Test plan
- Reset/idle: hold pins_in=0xFF through reset, release, run 10 cycles -> all flags 0x00, irq=0; read address 0 -> data_out=0xFF with ready_r one cycle after read.
- Edge capture: armed, drive port0 0x00->0x05 -> flags[0]=0x05 at k+2; drive 0x05->0x01 -> flags[0]=0x05 (bit2 re-set, already set).
- W1C and race: flags[0]=0x0F; write 0x03 to address size -> flags=0x0C. Repeat with a new edge on bit0 in the same cycle as the clear -> bit0 remains 1.
- Interrupt: write mask[0]=0x10, toggle bit4 -> irq=1 after k+2. Write 0x10 to flags[0] -> irq=0 the next cycle. Toggle bit3 only -> irq stays 0.
- Bus corners: read address 3*size -> 0x00 with ready_r=1. Write there -> no register changes, ready_w=1. Simultaneous read/write of mask[0] (old 0xAA, new 0x55) -> data_out=0xAA, a subsequent read returns 0x55.
- Reset mid-operation: assert reset while flags, mask, and irq are nonzero and read is high -> all outputs 0 immediately, ready_r=0 the next cycle.
